// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag-vector layout for the pipelined ALU.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SLL = 6'b000000;

  localparam int FLG_CARRY = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_NEG   = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_INV   = 4;
  localparam int NB_FLAGS  = 5;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: maps operands and opcode to a result and flag vector.
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6
) (
  input  logic [NB_DATA-1:0]   i_op_1,
  input  logic [NB_DATA-1:0]   i_op_2,
  input  logic [NB_OPCODE-1:0] i_opcode,
  output logic [NB_DATA-1:0]   o_result,
  output logic [NB_FLAGS-1:0]  o_flags
);

  localparam int NB_SHAMT = $clog2(NB_DATA) + 1;
  localparam int MSB      = NB_DATA - 1;

  logic [NB_SHAMT-1:0] shamt;
  logic                shift_big;
  logic [NB_DATA:0]    sum_ext;
  logic [NB_DATA:0]    diff_ext;
  logic [NB_DATA-1:0]  res;
  logic                carry;
  logic                ovf;
  logic                inv;

  assign shamt     = i_op_2[NB_SHAMT-1:0];
  assign shift_big = (int'(shamt) >= NB_DATA);
  // Bit NB_DATA of the widened difference is the unsigned borrow.
  assign sum_ext   = {1'b0, i_op_1} + {1'b0, i_op_2};
  assign diff_ext  = {1'b0, i_op_1} - {1'b0, i_op_2};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    inv   = 1'b0;
    case (i_opcode)
      NB_OPCODE'(OP_ADD): begin
        res   = sum_ext[MSB:0];
        carry = sum_ext[NB_DATA];
        ovf   = (i_op_1[MSB] == i_op_2[MSB]) && (sum_ext[MSB] != i_op_1[MSB]);
      end
      NB_OPCODE'(OP_SUB): begin
        res   = diff_ext[MSB:0];
        carry = diff_ext[NB_DATA];
        ovf   = (i_op_1[MSB] != i_op_2[MSB]) && (diff_ext[MSB] != i_op_1[MSB]);
      end
      NB_OPCODE'(OP_AND): res = i_op_1 & i_op_2;
      NB_OPCODE'(OP_OR):  res = i_op_1 | i_op_2;
      NB_OPCODE'(OP_XOR): res = i_op_1 ^ i_op_2;
      NB_OPCODE'(OP_NOR): res = ~(i_op_1 | i_op_2);
      NB_OPCODE'(OP_SRA): res = shift_big ? {NB_DATA{i_op_1[MSB]}}
                                          : NB_DATA'($signed(i_op_1) >>> shamt);
      NB_OPCODE'(OP_SRL): res = shift_big ? '0 : (i_op_1 >> shamt);
      NB_OPCODE'(OP_SLL): res = shift_big ? '0 : (i_op_1 << shamt);
      default:            inv = 1'b1;
    endcase
  end

  always_comb begin
    o_result           = res;
    o_flags            = '0;
    o_flags[FLG_CARRY] = carry;
    o_flags[FLG_ZERO]  = (res == '0);
    o_flags[FLG_NEG]   = res[MSB];
    o_flags[FLG_OVF]   = ovf;
    o_flags[FLG_INV]   = inv;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NB_DATA-1:0]   i_op_1,
  input  logic [NB_DATA-1:0]   i_op_2,
  input  logic [NB_OPCODE-1:0] i_opcode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_carry,
  output logic                 o_zero,
  output logic                 o_negative,
  output logic                 o_overflow,
  output logic                 o_invalid_op
);

  logic                 ready_en;
  logic                 s1_valid;
  logic [NB_DATA-1:0]   s1_op_1;
  logic [NB_DATA-1:0]   s1_op_2;
  logic [NB_OPCODE-1:0] s1_opcode;
  logic [NB_DATA-1:0]   s2_result;
  logic [NB_FLAGS-1:0]  s2_flags;
  logic [NB_DATA-1:0]   core_result;
  logic [NB_FLAGS-1:0]  core_flags;
  logic                 s1_load;
  logic                 s2_load;
  logic                 accept;

  // ready_en keeps o_ready low until the first edge after reset release.
  assign s2_load = !o_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = ready_en && s1_load;
  assign accept  = i_valid && o_ready;

  alu_core #(
    .NB_DATA   (NB_DATA),
    .NB_OPCODE (NB_OPCODE)
  ) u_core (
    .i_op_1   (s1_op_1),
    .i_op_2   (s1_op_2),
    .i_opcode (s1_opcode),
    .o_result (core_result),
    .o_flags  (core_flags)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_en  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_op_1   <= '0;
      s1_op_2   <= '0;
      s1_opcode <= '0;
    end else begin
      ready_en <= 1'b1;
      if (s1_load) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_op_1   <= i_op_1;
        s1_op_2   <= i_op_2;
        s1_opcode <= i_opcode;
      end
    end
  end

  // Result registers only change when a real transaction moves into S2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_flags  <= core_flags;
      end
    end
  end

  assign o_result     = s2_result;
  assign o_carry      = s2_flags[FLG_CARRY];
  assign o_zero       = s2_flags[FLG_ZERO];
  assign o_negative   = s2_flags[FLG_NEG];
  assign o_overflow   = s2_flags[FLG_OVF];
  assign o_invalid_op = s2_flags[FLG_INV];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: arithmetic, shifts, back-pressure and async reset.
module tb_alu_pipe;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_op_1;
  logic [7:0] i_op_2;
  logic [5:0] i_opcode;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_result;
  logic       o_carry;
  logic       o_zero;
  logic       o_negative;
  logic       o_overflow;
  logic       o_invalid_op;

  int total;
  int bad;

  alu_pipe #(.NB_DATA(8), .NB_OPCODE(6)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_op_1       (i_op_1),
    .i_op_2       (i_op_2),
    .i_opcode     (i_opcode),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_carry      (o_carry),
    .o_zero       (o_zero),
    .o_negative   (o_negative),
    .o_overflow   (o_overflow),
    .o_invalid_op (o_invalid_op)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Flags are packed as {carry, zero, negative, overflow, invalid_op}.
  function automatic logic [4:0] outFlags();
    return {o_carry, o_zero, o_negative, o_overflow, o_invalid_op};
  endfunction

  // One transaction with the consumer always ready; result checked two edges after acceptance.
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] exp_res,
                               input logic [4:0] exp_flags);
    @(negedge i_clk);
    i_ready  = 1'b1;
    i_valid  = 1'b1;
    i_opcode = op;
    i_op_1   = a;
    i_op_2   = b;
    #1;
    checkOutput({tag, "_rdy"}, 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    checkOutput(tag, 32'({o_valid, o_result, outFlags()}), 32'({1'b1, exp_res, exp_flags}));
  endtask

  initial begin
    int sent;
    int got;
    logic [7:0] exp_strm;

    total    = 0;
    bad      = 0;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_op_1   = '0;
    i_op_2   = '0;
    i_opcode = '0;

    #12;
    checkOutput("rst_outputs", 32'({o_ready, o_valid, o_result, outFlags()}), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("post_rst_ready", 32'({o_ready, o_valid}), 32'b10);

    applyStimulus("add_ovf",    6'b100000, 8'h7F, 8'h01, 8'h80, 5'b00110);
    applyStimulus("add_carry",  6'b100000, 8'hFF, 8'h01, 8'h00, 5'b11000);
    applyStimulus("sub_borrow", 6'b100010, 8'h03, 8'h05, 8'hFE, 5'b10100);
    applyStimulus("sub_ovf",    6'b100010, 8'h80, 8'h01, 8'h7F, 5'b00010);
    applyStimulus("and",        6'b100100, 8'hC3, 8'h5A, 8'h42, 5'b00000);
    applyStimulus("or",         6'b100101, 8'hC3, 8'h5A, 8'hDB, 5'b00100);
    applyStimulus("xor",        6'b100110, 8'hC3, 8'h5A, 8'h99, 5'b00100);
    applyStimulus("nor",        6'b100111, 8'hC3, 8'h5A, 8'h24, 5'b00000);
    applyStimulus("sra2",       6'b000011, 8'h90, 8'h02, 8'hE4, 5'b00100);
    applyStimulus("srl2",       6'b000010, 8'h90, 8'h02, 8'h24, 5'b00000);
    applyStimulus("sll3",       6'b000000, 8'h90, 8'h03, 8'h80, 5'b00100);
    applyStimulus("sra9",       6'b000011, 8'h90, 8'h09, 8'hFF, 5'b00100);
    applyStimulus("sra8_pos",   6'b000011, 8'h70, 8'h08, 8'h00, 5'b01000);
    applyStimulus("srl8",       6'b000010, 8'h90, 8'h08, 8'h00, 5'b01000);
    applyStimulus("sll8",       6'b000000, 8'h90, 8'h08, 8'h00, 5'b01000);
    applyStimulus("invalid",    6'b111111, 8'h05, 8'h03, 8'h00, 5'b01001);

    // Stream 4 ADDs (k+k) with the consumer stalled for the first 5 cycles.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge i_clk);
      i_ready = (cyc >= 5);
      if (sent < 4) begin
        i_valid  = 1'b1;
        i_opcode = 6'b100000;
        i_op_1   = 8'(sent + 1);
        i_op_2   = 8'(sent + 1);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc < 5) begin
        checkOutput("stall_ready_low", 32'(o_ready), 32'd0);
        checkOutput("stall_hold", 32'({o_valid, o_result, outFlags()}), 32'({1'b1, 8'h02, 5'b0}));
      end
      if (o_valid && i_ready) begin
        exp_strm = 8'(2 * (got + 1));
        checkOutput($sformatf("stream_%0d", got), 32'({o_result, outFlags()}),
                    32'({exp_strm, 5'b0}));
        got++;
      end
      if (i_valid && o_ready) sent++;
    end
    checkOutput("stream_count", 32'(got), 32'd4);
    @(negedge i_clk);
    i_valid = 1'b0;
    checkOutput("stream_no_dup", 32'(o_valid), 32'd0);

    // Async reset between edges while a result is presented.
    @(negedge i_clk);
    i_ready  = 1'b1;
    i_valid  = 1'b1;
    i_opcode = 6'b100000;
    i_op_1   = 8'h05;
    i_op_2   = 8'h06;
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    checkOutput("pre_rst_valid", 32'({o_valid, o_result}), 32'({1'b1, 8'h0B}));
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_outputs", 32'({o_ready, o_valid, o_result, outFlags()}), 32'd0);
    i_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("post_rst2_empty", 32'({o_ready, o_valid}), 32'b10);
    applyStimulus("after_rst", 6'b100000, 8'h10, 8'h20, 8'h30, 5'b00000);
    @(negedge i_clk);
    checkOutput("after_rst_drain", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
